// File: rtl/irq_pkg.sv
// Shared definitions for the machine-level interrupt controller: register map,
// FSM state encoding and reset constants.
package irq_pkg;

  localparam logic [2:0] IRQ_ENABLE   = 3'd0;
  localparam logic [2:0] IRQ_PENDING  = 3'd1;
  localparam logic [2:0] IRQ_CLAIM    = 3'd2;
  localparam logic [2:0] IRQ_COMPLETE = 3'd3;
  localparam logic [2:0] IRQ_EDGE     = 3'd4;
  localparam logic [2:0] IRQ_MTIME    = 3'd5;
  localparam logic [2:0] IRQ_MTIMECMP = 3'd6;
  localparam logic [2:0] IRQ_PRESCALE = 3'd7;

  localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_timer.sv
// Machine timer: prescaler, free-running mtime, compare register and the
// registered active-low timer interrupt.
module irq_timer
  import irq_pkg::*;
#(
  parameter int unsigned PSW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2:0]     reg_addr,
  input  logic [31:0]    reg_wdata,
  input  logic           reg_we,
  output logic [31:0]    mtime,
  output logic [31:0]    mtimecmp,
  output logic [PSW-1:0] prescale,
  output logic           ti
);

  logic [PSW-1:0] psc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc      <= '0;
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      prescale <= '0;
      ti       <= 1'b1;
    end else begin
      ti <= ~(mtime >= mtimecmp);
      // >= rather than == so a PRESCALE write below the running count
      // does not force a full wrap of the prescaler.
      if (reg_we && reg_addr == IRQ_MTIME) begin
        mtime <= reg_wdata;
        psc   <= '0;
      end else if (psc >= prescale) begin
        mtime <= mtime + 32'd1;
        psc   <= '0;
      end else begin
        psc <= psc + 1'b1;
      end
      if (reg_we && reg_addr == IRQ_MTIMECMP) mtimecmp <= reg_wdata;
      if (reg_we && reg_addr == IRQ_PRESCALE) prescale <= reg_wdata[PSW-1:0];
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: source synchronisers, pending latches, fixed
// priority arbitration, claim/complete FSM and the register port.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NSRC = 8,
  parameter int unsigned PSW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src_n,
  input  logic [2:0]      reg_addr,
  input  logic [31:0]     reg_wdata,
  input  logic            reg_we,
  input  logic            reg_re,
  output logic [31:0]     reg_rdata,
  output logic            ei,
  output logic            ti
);

  logic [NSRC-1:0] sync1, sync2, s, s_d;
  logic [NSRC-1:0] enable, edge_sel, pending;
  logic [NSRC-1:0] set_vec, clr_vec, cand;
  logic [4:0]      claim_id, inservice_id;
  logic            found;
  logic            claim_rd, claim_fire, complete_fire;
  logic [31:0]     rd_val;
  logic [31:0]     mtime, mtimecmp;
  logic [PSW-1:0]  prescale;
  irq_state_e      state;

  assign s    = ~sync2;
  assign cand = pending & enable;

  always_comb begin
    found    = 1'b0;
    claim_id = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!found && cand[i]) begin
        claim_id = 5'(i + 1);
        found    = 1'b1;
      end
    end
  end

  assign claim_rd      = reg_re && reg_addr == IRQ_CLAIM;
  assign claim_fire    = claim_rd && state == PEND && claim_id != '0;
  assign complete_fire = reg_we && reg_addr == IRQ_COMPLETE && state == SERVICE
                         && reg_wdata[4:0] == inservice_id;

  // The source currently in service is masked so a held level line cannot
  // re-pend until its COMPLETE has been accepted.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      set_vec[i] = (edge_sel[i] ? (s[i] & ~s_d[i]) : s[i])
                   & ~(state == SERVICE && inservice_id == 5'(i + 1));
      clr_vec[i] = claim_fire && claim_id == 5'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '1;
      sync2   <= '1;
      s_d     <= '0;
      pending <= '0;
    end else begin
      sync1   <= src_n;
      sync2   <= sync1;
      s_d     <= s;
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= '0;
      edge_sel <= '0;
    end else if (reg_we) begin
      if (reg_addr == IRQ_ENABLE) enable   <= reg_wdata[NSRC-1:0];
      if (reg_addr == IRQ_EDGE)   edge_sel <= reg_wdata[NSRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      inservice_id <= '0;
      ei           <= 1'b1;
    end else begin
      ei <= ~(state == PEND);
      case (state)
        IDLE:    if (claim_id != '0) state <= PEND;
        PEND: begin
          if (claim_id == '0) begin
            state <= IDLE;
          end else if (claim_rd) begin
            state        <= SERVICE;
            inservice_id <= claim_id;
          end
        end
        SERVICE: if (complete_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      IRQ_ENABLE:   rd_val = 32'(enable);
      IRQ_PENDING:  rd_val = 32'(pending);
      IRQ_CLAIM:    rd_val = claim_fire ? 32'(claim_id) : '0;
      IRQ_EDGE:     rd_val = 32'(edge_sel);
      IRQ_MTIME:    rd_val = mtime;
      IRQ_MTIMECMP: rd_val = mtimecmp;
      IRQ_PRESCALE: rd_val = 32'(prescale);
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) reg_rdata <= '0;
    else if (reg_re) reg_rdata <= rd_val;
  end

  irq_timer #(.PSW(PSW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .mtime     (mtime),
    .mtimecmp  (mtimecmp),
    .prescale  (prescale),
    .ti        (ti)
  );

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register reads go through an expectation queue
// that is filled when the read is issued and drained when reg_rdata is valid.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  src_n = '1;
  logic [2:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [31:0] reg_rdata;
  logic        ei, ti;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(8), .PSW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_n     (src_n),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .ei        (ei),
    .ti        (ti)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    reg_we = 1'b1; reg_addr = addr; reg_wdata = data;
    @(posedge clk); #1;
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    reg_re = 1'b1; reg_addr = addr;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    reg_re = 1'b0;
    check(tag_q.pop_front(), reg_rdata, exp_q.pop_front());
  endtask

  task automatic pulse(input logic [7:0] mask);
    @(posedge clk); #1;
    src_n = src_n & ~mask;
    tick(1);
    src_n = src_n | mask;
  endtask

  task automatic wait_ei_low(input int bound, output int cnt);
    cnt = 0;
    while (ei !== 1'b0 && cnt < bound) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #23;
    check("rst_rdata", reg_rdata, 32'h0);
    check("rst_ei", 32'(ei), 32'h1);
    check("rst_ti", 32'(ti), 32'h1);
    rst_n = 1'b1;
    rd(IRQ_MTIMECMP, 32'hFFFF_FFFF, "rst_mtimecmp");
    rd(IRQ_ENABLE, 32'h0, "rst_enable");

    // Edge source 2
    wr(IRQ_EDGE, 32'hFF);
    wr(IRQ_ENABLE, 32'h04);
    pulse(8'h04);
    wait_ei_low(12, n);
    check("edge_ei_low", 32'(ei), 32'h0);
    rd(IRQ_PENDING, 32'h04, "edge_pending");
    rd(IRQ_CLAIM, 32'd3, "edge_claim");
    tick(1);
    check("edge_ei_release", 32'(ei), 32'h1);
    rd(IRQ_PENDING, 32'h0, "edge_pending_clr");
    wr(IRQ_COMPLETE, 32'd3);
    rd(IRQ_CLAIM, 32'd0, "idle_claim");

    // Priority and enable mask
    wr(IRQ_ENABLE, 32'h0A);
    pulse(8'h0A);
    wait_ei_low(12, n);
    check("prio_ei_low", 32'(ei), 32'h0);
    rd(IRQ_CLAIM, 32'd2, "prio_claim_first");
    wr(IRQ_COMPLETE, 32'd2);
    wait_ei_low(12, n);
    check("prio_ei_low2", 32'(ei), 32'h0);
    rd(IRQ_CLAIM, 32'd4, "prio_claim_second");
    wr(IRQ_COMPLETE, 32'd4);
    pulse(8'h01);
    tick(8);
    check("mask_ei_idle", 32'(ei), 32'h1);
    rd(IRQ_PENDING, 32'h01, "mask_pending");
    rd(IRQ_CLAIM, 32'd0, "mask_claim");

    // Level source 5 re-pends after complete
    wr(IRQ_EDGE, 32'hDF);
    wr(IRQ_ENABLE, 32'h20);
    src_n[5] = 1'b0;
    wait_ei_low(12, n);
    check("lvl_ei_low", 32'(ei), 32'h0);
    rd(IRQ_CLAIM, 32'd6, "lvl_claim");
    wr(IRQ_COMPLETE, 32'd7);
    rd(IRQ_CLAIM, 32'd0, "svc_claim_zero");
    tick(4);
    check("cmp7_ignored", 32'(ei), 32'h1);
    wr(IRQ_COMPLETE, 32'd6);
    wait_ei_low(10, n);
    check("repend_ei", 32'(ei), 32'h0);
    check("repend_latency", 32'(n <= 3), 32'h1);
    rd(IRQ_CLAIM, 32'd6, "repend_claim");

    // Asynchronous reset while in SERVICE with source 0 still pending
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_rdata", reg_rdata, 32'h0);
    check("areset_ei", 32'(ei), 32'h1);
    src_n = '1;
    tick(2);
    rst_n = 1'b1;
    rd(IRQ_PENDING, 32'h0, "areset_pending");
    rd(IRQ_ENABLE, 32'h0, "areset_enable");
    rd(IRQ_EDGE, 32'h0, "areset_edge");
    rd(IRQ_MTIMECMP, 32'hFFFF_FFFF, "areset_mtimecmp");

    // Timer
    wr(IRQ_PRESCALE, 32'd3);
    wr(IRQ_MTIME, 32'd0);
    wr(IRQ_MTIMECMP, 32'd10);
    check("tmr_ti_idle", 32'(ti), 32'h1);
    n = 0;
    while (ti !== 1'b0 && n < 100) begin
      tick(1);
      n++;
    end
    check("tmr_ti_low", 32'(ti), 32'h0);
    check("tmr_latency", 32'(n >= 37 && n <= 41), 32'h1);
    rd(IRQ_MTIME, 32'd10, "tmr_mtime");
    wr(IRQ_MTIMECMP, 32'hFFFF_FFFF);
    tick(1);
    check("tmr_ack", 32'(ti), 32'h1);
    wr(IRQ_MTIME, 32'hFFFF_FFFF);
    rd(IRQ_MTIME, 32'hFFFF_FFFF, "wrap_before");
    tick(2);
    rd(IRQ_MTIME, 32'h0, "wrap_after");
    rd(IRQ_PRESCALE, 32'd3, "prescale_rb");

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
